// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce, edge capture
// with write-1-to-clear, and a masked level interrupt.
module pio_input_edge_irq #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RSVD = 2'd1,
    REG_MASK = 2'd2,
    REG_EDGE = 2'd3
  } reg_e;

  localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned WW          = $clog2(WARM_CYCLES + 1);

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_stable;
  logic [DATA_WIDTH-1:0] r_stable_d;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_ev;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [WW-1:0]         r_warm;
  logic                  w_warm;
  logic                  w_wr;
  reg_e                  w_addr;
  logic [31:0]           w_rdmux;
  logic [31:0]           r_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign w_stable = w_sync;
    end else begin : g_db
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0]         r_cnt [DATA_WIDTH];
      logic [DATA_WIDTH-1:0] r_stable;

      // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stable <= '0;
          for (int unsigned i = 0; i < DATA_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (w_sync[i] == r_stable[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST) begin
              r_stable[i] <= w_sync[i];
              r_cnt[i]    <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end

      assign w_stable = r_stable;
    end
  endgenerate

  assign w_warm = (r_warm == WW'(WARM_CYCLES));
  assign w_rise = w_stable & ~r_stable_d;
  assign w_fall = ~w_stable & r_stable_d;

  always_comb begin
    w_ev = '0;
    if (EDGE_TYPE == 0)      w_ev = w_rise;
    else if (EDGE_TYPE == 1) w_ev = w_fall;
    else                     w_ev = w_rise | w_fall;
    // Inputs already high at power-up must not look like edges.
    if (!w_warm) w_ev = '0;
  end

  assign w_wr   = chipselect & write;
  assign w_addr = reg_e'(address);
  assign w_clr  = (w_wr && w_addr == REG_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    w_rdmux = '0;
    case (w_addr)
      REG_DATA: w_rdmux[DATA_WIDTH-1:0] = w_stable;
      REG_RSVD: w_rdmux = '0;
      REG_MASK: w_rdmux[DATA_WIDTH-1:0] = r_mask;
      REG_EDGE: w_rdmux[DATA_WIDTH-1:0] = r_edge;
      default:  w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable_d <= '0;
      r_warm     <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
    end else begin
      r_stable_d <= w_stable;
      if (!w_warm) r_warm <= r_warm + 1'b1;
      if (w_wr && w_addr == REG_MASK) r_mask <= writedata[DATA_WIDTH-1:0];
      // A new edge overrides a same-cycle clear of that bit.
      r_edge     <= w_ev | (r_edge & ~w_clr);
      r_readdata <= w_rdmux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Self-checking bench: three configurations of the input PIO on a shared bus,
// compared every cycle against a history-window reference model.
module tb_pio_input_edge_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [31:0] in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_input_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  pio_input_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

  pio_input_edge_irq #(.DATA_WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  function automatic int p_dw(int k); return (k == 2) ? 32 : 8; endfunction
  function automatic int p_s(int k);  return (k == 1) ? 3 : 2;  endfunction
  function automatic int p_d(int k);  return (k == 1) ? 4 : 0;  endfunction
  function automatic int p_et(int k); return (k == 0) ? 0 : ((k == 1) ? 2 : 1); endfunction

  // Reference state; m_hist[k][0] is the input seen at the most recent edge.
  bit [31:0] m_stable   [3];
  bit [31:0] m_stable_d [3];
  bit [31:0] m_mask     [3];
  bit [31:0] m_edge     [3];
  bit [31:0] m_rd       [3];
  int        m_n        [3];
  bit [31:0] m_hist     [3][8];

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic void model_edge(int k, bit [31:0] inp);
    bit [31:0] dm, sb, ev, clr, all1, any1, nxt;
    int s, d;
    dm = (p_dw(k) == 32) ? 32'hFFFF_FFFF : ((32'h1 << p_dw(k)) - 32'h1);
    s  = p_s(k);
    d  = p_d(k);
    if (reset) begin
      m_stable[k] = '0; m_stable_d[k] = '0; m_mask[k] = '0; m_edge[k] = '0;
      m_rd[k] = '0; m_n[k] = 0;
      for (int j = 0; j < 8; j++) m_hist[k][j] = '0;
      return;
    end
    sb = m_stable[k];
    case (address)
      2'd0:    m_rd[k] = sb;
      2'd2:    m_rd[k] = m_mask[k];
      2'd3:    m_rd[k] = m_edge[k];
      default: m_rd[k] = '0;
    endcase
    case (p_et(k))
      0:       ev = sb & ~m_stable_d[k];
      1:       ev = ~sb & m_stable_d[k];
      default: ev = sb ^ m_stable_d[k];
    endcase
    if (m_n[k] < s + 1) ev = '0;
    clr = (chipselect && write && address == 2'd3) ? (writedata & dm) : '0;
    m_edge[k] = (ev | (m_edge[k] & ~clr)) & dm;
    if (chipselect && write && address == 2'd2) m_mask[k] = writedata & dm;
    m_stable_d[k] = sb;
    // Debounced level follows the synchronised input only after d identical samples.
    all1 = '1; any1 = '0;
    for (int j = 0; j < d; j++) begin
      all1 &= m_hist[k][s-1+j];
      any1 |= m_hist[k][s-1+j];
    end
    nxt = (sb & any1) | all1;
    for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = inp & dm;
    m_stable[k] = (d == 0) ? m_hist[k][s-1] : nxt;
    if (m_n[k] < 100) m_n[k]++;
  endfunction

  task automatic tick();
    model_edge(0, {24'h0, in0});
    model_edge(1, {24'h0, in1});
    model_edge(2, in2);
    @(posedge clk);
    #1;
    check("rd0",  rd0, m_rd[0]);
    check("rd1",  rd1, m_rd[1]);
    check("rd2",  rd2, m_rd[2]);
    check("irq0", {31'h0, irq0}, {31'h0, |(m_edge[0] & m_mask[0])});
    check("irq1", {31'h0, irq1}, {31'h0, |(m_edge[1] & m_mask[1])});
    check("irq2", {31'h0, irq2}, {31'h0, |(m_edge[2] & m_mask[2])});
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0; writedata = '0;
    in0 = 8'hFF; in1 = 8'h00; in2 = 32'hFFFF_FFFF;
    ticks(3);
    reset = 1'b0;
    ticks(10);
    check("warm_rd0", rd0, 32'h0000_00FF);
    check("warm_irq0", {31'h0, irq0}, 32'h0);
    address = 2'd3;
    tick();
    check("warm_edge0", rd0, 32'h0);

    // Rising capture on bit 0
    wr(2'd2, 32'h1);
    address = 2'd3;
    in0 = 8'hFE; ticks(4);
    in0 = 8'hFF; ticks(3);
    check("rise_irq0", {31'h0, irq0}, 32'h1);
    tick();
    check("rise_edge0", rd0, 32'h1);
    in0 = 8'hFE; ticks(5);
    check("fall_hold0", rd0, 32'h1);

    // Write-1-to-clear, then clear colliding with a new edge
    wr(2'd3, 32'h1);
    check("w1c_irq0", {31'h0, irq0}, 32'h0);
    in0 = 8'hFF; ticks(2);
    wr(2'd3, 32'h1);
    check("collide_irq0", {31'h0, irq0}, 32'h1);

    // Mask gating
    in0 = 8'hF2; ticks(4);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h3);
    in0 = 8'hFE; ticks(4);
    check("gated_irq0", {31'h0, irq0}, 32'h0);
    wr(2'd2, 32'h4);
    check("unmask_irq0", {31'h0, irq0}, 32'h1);
    tick();
    check("mask_rd0", rd0, 32'h4);

    // Debounce: short pulse rejected, long level accepted
    address = 2'd0;
    in1 = 8'h02; ticks(3);
    in1 = 8'h00; ticks(10);
    check("glitch_rd1", rd1, 32'h0);
    address = 2'd3; tick();
    check("glitch_edge1", rd1, 32'h0);
    address = 2'd0;
    in1 = 8'h02; ticks(12);
    check("level_rd1", rd1, 32'h2);
    address = 2'd3; tick();
    check("level_edge1", rd1, 32'h2);

    // Full width, falling edges
    wr(2'd3, 32'hFFFF_FFFF);
    in2 = 32'hA5A5_A5A5; ticks(4);
    address = 2'd3; tick();
    check("fall_edge2", rd2, 32'h5A5A_5A5A);
    address = 2'd1; tick();
    check("rsvd_rd2", rd2, 32'h0);
    wr(2'd0, 32'h1234_5678);
    address = 2'd0; tick();
    check("ro_rd2", rd2, 32'hA5A5_A5A5);

    // Randomised traffic, including a reset in the middle
    for (int c = 0; c < 600; c++) begin
      reset = (c == 250 || c == 251);
      if ($urandom_range(0, 7) == 0) in0 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) in1 = in1 ^ (8'h1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) in2 = $urandom;
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write      = ($urandom_range(0, 3) == 0);
      writedata  = $urandom;
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
